// File: rtl/dot_product_sequencer_if.sv
// Bus between the dot-product sequencer and the shared ram_reader, multiply and
// accumulator resources. The master side is the sequencer.
interface dot_product_sequencer_if #(
  parameter int ADDR_WIDTH = 27
);
  logic                  read_req;
  logic [ADDR_WIDTH-1:0] read_address;
  logic                  read_data_valid;
  logic [15:0]           ram_data_out;
  logic                  mul_valid;
  logic [15:0]           mul_a;
  logic [15:0]           mul_b;
  logic                  mul_result_valid;
  logic [15:0]           mul_result;
  logic                  acc_valid;
  logic [15:0]           acc_data;
  logic                  acc_last;
  logic [15:0]           acc_result;
  logic                  acc_result_last;

  modport master (
    output read_req, read_address, mul_valid, mul_a, mul_b, acc_valid, acc_data, acc_last,
    input  read_data_valid, ram_data_out, mul_result_valid, mul_result, acc_result, acc_result_last
  );

  modport slave (
    input  read_req, read_address, mul_valid, mul_a, mul_b, acc_valid, acc_data, acc_last,
    output read_data_valid, ram_data_out, mul_result_valid, mul_result, acc_result, acc_result_last
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Sequences one FP16 dot product: reads A/B element pairs, multiplies them, streams
// products to the accumulator with tlast on the final element and captures the sum.
module dot_product_sequencer #(
  parameter int ADDR_WIDTH     = 27,
  parameter int LEN_WIDTH      = 12,
  parameter int ADDR_STRIDE    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  dot_product_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           result
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]       TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(ADDR_STRIDE);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    REQ_A    = 4'd1,
    WAIT_A   = 4'd2,
    REQ_B    = 4'd3,
    WAIT_B   = 4'd4,
    MUL      = 4'd5,
    WAIT_MUL = 4'd6,
    ACC      = 4'd7,
    WAIT_ACC = 4'd8,
    DONE     = 4'd9
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] ptr_a_r;
  logic [ADDR_WIDTH-1:0] ptr_b_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  idx_r;
  logic [15:0]           op_a_r;
  logic [TO_W-1:0]       tmo_r;
  logic                  tmo_expired_s;
  logic                  last_s;

  assign tmo_expired_s = (tmo_r == TO_LAST);
  assign last_s        = (idx_r == (len_r - LEN_WIDTH'(1)));

  // Sequencer state, datapath registers and registered outputs; strobes are high
  // exactly while the FSM sits in their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      ptr_a_r          <= {ADDR_WIDTH{1'b0}};
      ptr_b_r          <= {ADDR_WIDTH{1'b0}};
      len_r            <= {LEN_WIDTH{1'b0}};
      idx_r            <= {LEN_WIDTH{1'b0}};
      op_a_r           <= 16'h0000;
      tmo_r            <= {TO_W{1'b0}};
      bus.read_req     <= 1'b0;
      bus.read_address <= {ADDR_WIDTH{1'b0}};
      bus.mul_valid    <= 1'b0;
      bus.mul_a        <= 16'h0000;
      bus.mul_b        <= 16'h0000;
      bus.acc_valid    <= 1'b0;
      bus.acc_data     <= 16'h0000;
      bus.acc_last     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      result           <= 16'h0000;
    end else begin
      bus.read_req  <= 1'b0;
      bus.mul_valid <= 1'b0;
      bus.acc_valid <= 1'b0;
      bus.acc_last  <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            ptr_a_r <= base_a;
            ptr_b_r <= base_b;
            len_r   <= vec_len;
            idx_r   <= {LEN_WIDTH{1'b0}};
            result  <= 16'h0000;
            if (vec_len == {LEN_WIDTH{1'b0}}) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              busy             <= 1'b1;
              bus.read_req     <= 1'b1;
              bus.read_address <= base_a;
              state_r          <= REQ_A;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ_A: begin
          tmo_r   <= {TO_W{1'b0}};
          state_r <= WAIT_A;
        end
        WAIT_A: begin
          // Timeout is checked first so it wins over a same-cycle strobe.
          if (tmo_expired_s) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (bus.read_data_valid) begin
            op_a_r           <= bus.ram_data_out;
            bus.read_req     <= 1'b1;
            bus.read_address <= ptr_b_r;
            state_r          <= REQ_B;
          end else begin
            tmo_r <= tmo_r + TO_W'(1);
          end
        end
        REQ_B: begin
          tmo_r   <= {TO_W{1'b0}};
          state_r <= WAIT_B;
        end
        WAIT_B: begin
          if (tmo_expired_s) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (bus.read_data_valid) begin
            bus.mul_valid <= 1'b1;
            bus.mul_a     <= op_a_r;
            bus.mul_b     <= bus.ram_data_out;
            state_r       <= MUL;
          end else begin
            tmo_r <= tmo_r + TO_W'(1);
          end
        end
        MUL: begin
          tmo_r   <= {TO_W{1'b0}};
          state_r <= WAIT_MUL;
        end
        WAIT_MUL: begin
          if (tmo_expired_s) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (bus.mul_result_valid) begin
            bus.acc_valid <= 1'b1;
            bus.acc_data  <= bus.mul_result;
            bus.acc_last  <= last_s;
            state_r       <= ACC;
          end else begin
            tmo_r <= tmo_r + TO_W'(1);
          end
        end
        ACC: begin
          if (last_s) begin
            tmo_r   <= {TO_W{1'b0}};
            state_r <= WAIT_ACC;
          end else begin
            idx_r            <= idx_r + LEN_WIDTH'(1);
            ptr_a_r          <= ptr_a_r + STRIDE;
            ptr_b_r          <= ptr_b_r + STRIDE;
            bus.read_req     <= 1'b1;
            bus.read_address <= ptr_a_r + STRIDE;
            state_r          <= REQ_A;
          end
        end
        WAIT_ACC: begin
          // The accumulator has already taken tlast, so an abort here needs no flush.
          if (tmo_expired_s) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (bus.acc_result_last) begin
            result  <= bus.acc_result;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end else begin
            tmo_r <= tmo_r + TO_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench: behavioural memory/multiply/accumulator responders, a
// queue-based reference model of the expected bus traffic and one compare process.
module tb_dot_product_sequencer;

  localparam int RD_LAT  = 2;
  localparam int MUL_LAT = 4;
  localparam int ACC_LAT = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [26:0] base_a;
  logic [26:0] base_b;
  logic [11:0] vec_len;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] result;

  dot_product_sequencer_if #(.ADDR_WIDTH(27)) bus_if ();

  dot_product_sequencer #(
    .ADDR_WIDTH(27), .LEN_WIDTH(12), .ADDR_STRIDE(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_a(base_a), .base_b(base_b),
    .vec_len(vec_len), .bus(bus_if), .busy(busy), .done(done), .error(error),
    .result(result)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rr_cnt = 0, mv_cnt = 0, av_cnt = 0, al_cnt = 0, done_cnt = 0, err_cnt = 0;
  int rr_cyc = 0, done_cyc = 0, err_cyc = 0;
  int snap_done = 0, snap_err = 0, start_cyc = 0;
  bit withhold_rd = 1'b0;

  logic [15:0] mem [int];
  logic [26:0] exp_addr [$];
  logic [31:0] exp_mul  [$];
  logic [16:0] exp_acc  [$];
  logic [26:0] obs_addr [$];
  logic [15:0] exp_result = 16'h0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: strobe seen with nothing expected", name);
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) begin
      for (int i = 0; i < e; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -e; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m = real'(h[9:0]);
    real r;
    if (e == 0) r = m * pow2(-24);
    else        r = (1.0 + m / 1024.0) * pow2(e - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  x;
    int   e = 0;
    int   m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    x = s ? -r : r;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    m = int'((x - 1.0) * 1024.0);
    if (m == 1024) begin m = 0; e++; end
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  function automatic logic [15:0] mem_rd(input logic [26:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 16'h0000;
  endfunction

  // Reference model: the whole transaction as plain loops over the vectors.
  task automatic build_model(input logic [26:0] a, input logic [26:0] b, input int n);
    real sum = 0.0;
    exp_addr.delete(); exp_mul.delete(); exp_acc.delete();
    for (int i = 0; i < n; i++) begin
      logic [26:0] aa = a + 27'(i);
      logic [26:0] bb = b + 27'(i);
      logic [15:0] p  = r2h(h2r(mem_rd(aa)) * h2r(mem_rd(bb)));
      exp_addr.push_back(aa);
      exp_addr.push_back(bb);
      exp_mul.push_back({mem_rd(aa), mem_rd(bb)});
      exp_acc.push_back({(i == n - 1), p});
      sum += h2r(p);
    end
    exp_result = r2h(sum);
  endtask

  // Responders: fixed-latency memory, multiplier and accumulator.
  initial begin
    int rd_cnt = 0, mul_cnt = 0, acc_cnt = 0;
    logic [26:0] rd_addr = 27'h0;
    logic [15:0] mul_pend = 16'h0, acc_out = 16'h0;
    real acc_sum = 0.0;
    bus_if.read_data_valid = 1'b0; bus_if.ram_data_out = 16'h0;
    bus_if.mul_result_valid = 1'b0; bus_if.mul_result = 16'h0;
    bus_if.acc_result_last = 1'b0; bus_if.acc_result = 16'h0;
    forever begin
      @(negedge clk);
      bus_if.read_data_valid = 1'b0;
      bus_if.mul_result_valid = 1'b0;
      bus_if.acc_result_last = 1'b0;
      if (reset) begin
        rd_cnt = 0; mul_cnt = 0; acc_cnt = 0; acc_sum = 0.0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0 && !withhold_rd) begin
            bus_if.read_data_valid = 1'b1;
            bus_if.ram_data_out = mem_rd(rd_addr);
          end
        end
        if (bus_if.read_req) begin rd_cnt = RD_LAT; rd_addr = bus_if.read_address; end
        if (mul_cnt > 0) begin
          mul_cnt--;
          if (mul_cnt == 0) begin bus_if.mul_result_valid = 1'b1; bus_if.mul_result = mul_pend; end
        end
        if (bus_if.mul_valid) begin
          mul_cnt = MUL_LAT;
          mul_pend = r2h(h2r(bus_if.mul_a) * h2r(bus_if.mul_b));
        end
        if (acc_cnt > 0) begin
          acc_cnt--;
          if (acc_cnt == 0) begin bus_if.acc_result_last = 1'b1; bus_if.acc_result = acc_out; end
        end
        if (bus_if.acc_valid) begin
          acc_sum += h2r(bus_if.acc_data);
          if (bus_if.acc_last) begin acc_out = r2h(acc_sum); acc_sum = 0.0; acc_cnt = ACC_LAT; end
        end
      end
    end
  end

  // Compare process: every strobe is checked against the model queues.
  initial begin
    logic [26:0] ea;
    logic [31:0] em;
    logic [16:0] ec;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (bus_if.read_req) begin
          rr_cnt++; rr_cyc = cyc; obs_addr.push_back(bus_if.read_address);
          if (exp_addr.size() == 0) unexpected("read_req");
          else begin ea = exp_addr.pop_front(); chk("read_address", 32'(bus_if.read_address), 32'(ea)); end
        end
        if (bus_if.mul_valid) begin
          mv_cnt++;
          if (exp_mul.size() == 0) unexpected("mul_valid");
          else begin em = exp_mul.pop_front(); chk("mul_operands", {bus_if.mul_a, bus_if.mul_b}, em); end
        end
        if (bus_if.acc_valid) begin
          av_cnt++;
          if (bus_if.acc_last) al_cnt++;
          if (exp_acc.size() == 0) unexpected("acc_valid");
          else begin ec = exp_acc.pop_front(); chk("acc_last_data", 32'({bus_if.acc_last, bus_if.acc_data}), 32'(ec)); end
        end
        if (done || error) chk("done_error_exclusive", 32'(done & error), 32'd0);
        if (done) begin
          done_cnt++; done_cyc = cyc;
          chk("result_at_done", 32'(result), 32'(exp_result));
          chk("busy_at_done", 32'(busy), 32'd0);
        end
        if (error) begin
          err_cnt++; err_cyc = cyc;
          chk("busy_at_error", 32'(busy), 32'd0);
          chk("result_at_error", 32'(result), 32'd0);
        end
      end
    end
  end

  task automatic pulse_start(input logic [26:0] a, input logic [26:0] b, input logic [11:0] n);
    @(negedge clk); #1;
    base_a = a; base_b = b; vec_len = n; start = 1'b1;
    snap_done = done_cnt; snap_err = err_cnt; start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc);
    int n = 0;
    while (done_cnt == snap_done && err_cnt == snap_err && n < max_cyc) begin
      @(negedge clk); #1; n++;
    end
    if (done_cnt == snap_done && err_cnt == snap_err) begin
      checks++; errors++;
      $display("FAIL wait_end: no done/error within %0d cycles", max_cyc);
    end
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_addr_queue"}, 32'(exp_addr.size()), 32'd0);
    chk({tag, "_mul_queue"},  32'(exp_mul.size()),  32'd0);
    chk({tag, "_acc_queue"},  32'(exp_acc.size()),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, m0, a0, n;
    reset = 1'b1; start = 1'b0; base_a = 27'h0; base_b = 27'h0; vec_len = 12'h0;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done_error", 32'({done, error}), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_strobes", 32'({bus_if.read_req, bus_if.mul_valid, bus_if.acc_valid, bus_if.acc_last}), 32'd0);
    chk("reset_read_address", 32'(bus_if.read_address), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Pin the model's FP16 arithmetic with hand-computed values.
    chk("model_mul_2x1", 32'(r2h(h2r(16'h4000) * h2r(16'h3C00))), 32'h4000);
    chk("model_sum_1_2_3", 32'(r2h(h2r(16'h3C00) + h2r(16'h4000) + h2r(16'h4200))), 32'h4600);

    // Three-element product: 1*1 + 2*1 + 3*1 = 6.0.
    mem[32'h100] = 16'h3C00; mem[32'h101] = 16'h4000; mem[32'h102] = 16'h4200;
    mem[32'h200] = 16'h3C00; mem[32'h201] = 16'h3C00; mem[32'h202] = 16'h3C00;
    build_model(27'h100, 27'h200, 3);
    a0 = al_cnt;
    pulse_start(27'h100, 27'h200, 12'd3);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_end(300);
    chk("len3_result", 32'(result), 32'h4600);
    chk("len3_done_count", 32'(done_cnt - snap_done), 32'd1);
    chk("len3_acc_last_count", 32'(al_cnt - a0), 32'd1);
    check_drained("len3");

    // Zero length: done in the cycle after the start cycle, no traffic.
    build_model(27'h100, 27'h200, 0);
    r0 = rr_cnt; m0 = mv_cnt; a0 = av_cnt;
    pulse_start(27'h100, 27'h200, 12'd0);
    wait_end(20);
    chk("len0_done_cycle", 32'(done_cyc - start_cyc + 1), 32'd2);
    chk("len0_no_strobes", 32'((rr_cnt - r0) + (mv_cnt - m0) + (av_cnt - a0)), 32'd0);
    chk("len0_result", 32'(result), 32'h0000);

    // Start re-pulsed while busy with other parameters must be ignored.
    mem[32'h300] = 16'h4000; mem[32'h301] = 16'h3C00;
    mem[32'h400] = 16'h4000; mem[32'h401] = 16'h4400;
    build_model(27'h300, 27'h400, 2);
    pulse_start(27'h300, 27'h400, 12'd2);
    @(negedge clk); #1;
    base_a = 27'h999; vec_len = 12'd5; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_end(300);
    repeat (40) @(negedge clk);
    #1;
    chk("repulse_result", 32'(result), 32'h4800);
    chk("repulse_done_count", 32'(done_cnt - snap_done), 32'd1);
    check_drained("repulse");

    // Withheld read data: error 16 cycles after WAIT_A begins (the cycle after read_req).
    withhold_rd = 1'b1;
    exp_addr.delete(); exp_mul.delete(); exp_acc.delete();
    exp_addr.push_back(27'h700);
    r0 = rr_cnt;
    pulse_start(27'h700, 27'h800, 12'd1);
    wait_end(100);
    chk("timeout_error_cycle", 32'(err_cyc - rr_cyc), 32'd17);
    chk("timeout_error_count", 32'(err_cnt - snap_err), 32'd1);
    chk("timeout_no_done", 32'(done_cnt - snap_done), 32'd0);
    chk("timeout_reads", 32'(rr_cnt - r0), 32'd1);
    withhold_rd = 1'b0;
    repeat (4) @(negedge clk);
    check_drained("timeout");

    // Address wrap: second A read at 0x0000000.
    mem[32'h7FFFFFF] = 16'h3C00; mem[32'h0] = 16'h4000;
    mem[32'h10] = 16'h4000; mem[32'h11] = 16'h3C00;
    build_model(27'h7FFFFFF, 27'h10, 2);
    obs_addr.delete();
    pulse_start(27'h7FFFFFF, 27'h10, 12'd2);
    wait_end(300);
    if (obs_addr.size() >= 3) chk("wrap_second_a_address", 32'(obs_addr[2]), 32'h0);
    else chk("wrap_read_count", 32'(obs_addr.size()), 32'd4);
    chk("wrap_result", 32'(result), 32'h4400);
    check_drained("wrap");

    // Asynchronous reset while in WAIT_MUL, then a normal run.
    mem[32'h500] = 16'h4200; mem[32'h600] = 16'h4000;
    build_model(27'h500, 27'h600, 1);
    m0 = mv_cnt;
    pulse_start(27'h500, 27'h600, 12'd1);
    n = 0;
    while (mv_cnt == m0 && n < 100) begin @(negedge clk); #1; n++; end
    chk("mid_reset_reached_mul", 32'(mv_cnt - m0), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_operands", 32'({bus_if.mul_a, bus_if.mul_b}), 32'd0);
    chk("mid_reset_address", 32'(bus_if.read_address), 32'd0);
    chk("mid_reset_strobes", 32'({bus_if.read_req, bus_if.mul_valid, bus_if.acc_valid, done, error}), 32'd0);
    @(negedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    build_model(27'h500, 27'h600, 1);
    pulse_start(27'h500, 27'h600, 12'd1);
    wait_end(300);
    chk("after_reset_result", 32'(result), 32'h4600);
    chk("after_reset_done_count", 32'(done_cnt - snap_done), 32'd1);
    check_drained("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
- Sequences one FP16 dot product over two vectors stored in DDR3: fetches element pairs through the ram_reader word-read port, feeds the multiply core, streams products into the accumulator core with tlast on the final element, and captures the sum.
- Sits between inference_fsm, which issues start and consumes the result, and the shared ram_reader/multiply/accumulator resources.
- Runs one element at a time with at most one outstanding read or multiply.

Parameters:
- ADDR_WIDTH, 27, DDR3 word address width.
- LEN_WIDTH, 12, vector length counter width.
- ADDR_STRIDE, 1, address increment per element, in 16-bit words.
- TIMEOUT_CYCLES, 1024, maximum wait for any read_data_valid, mul_result_valid or acc_result_last before aborting.

Ports:
- clk  in  1  ui_clk domain clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an operation when idle.
- base_a  in  ADDR_WIDTH  address of vector A element 0.
- base_b  in  ADDR_WIDTH  address of vector B element 0.
- vec_len  in  LEN_WIDTH  element count.
- read_req  out  1  one-cycle read strobe to ram_reader.
- read_address  out  ADDR_WIDTH  word address; held until read_data_valid.
- read_data_valid  in  1  read data strobe.
- ram_data_out  in  16  FP16 read word.
- mul_valid  out  1  multiply input valid (a and b).
- mul_a, mul_b  out  16  multiply operands.
- mul_result_valid  in  1  product valid.
- mul_result  in  16  FP16 product.
- acc_valid  out  1  accumulator input tvalid.
- acc_data  out  16  accumulator input tdata.
- acc_last  out  1  accumulator input tlast.
- acc_result  in  16  accumulator tdata.
- acc_result_last  in  1  accumulator tlast; marks the final sum.
- busy  out  1  high from accepted start until done or error.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle timeout pulse.
- result  out  16  captured sum; holds until the next accepted start.

Behaviour:
- Reset, asynchronous: state IDLE; every output, index, address and register is 0.
- States:
  - IDLE: on start, latch base_a, base_b and vec_len; clear result; busy=1. If vec_len==0, go to DONE with result=0x0000 and issue no reads. Otherwise go to REQ_A.
  - REQ_A: read_req=1 for 1 cycle; read_address = base_a + idx*ADDR_STRIDE. Go to WAIT_A.
  - WAIT_A: on read_data_valid, latch ram_data_out into op_a; go to REQ_B.
  - REQ_B / WAIT_B: same as REQ_A / WAIT_A using base_b; latch op_b; go to MUL.
  - MUL: mul_valid=1 for exactly 1 cycle with mul_a=op_a, mul_b=op_b. Go to WAIT_MUL.
  - WAIT_MUL: on mul_result_valid, go to ACC with the product registered.
  - ACC: acc_valid=1 for 1 cycle; acc_data=product; acc_last=(idx==len-1). If last, go to WAIT_ACC; else idx++ and go to REQ_A.
  - WAIT_ACC: on acc_result_last, result<=acc_result; go to DONE.
  - DONE: done=1 for 1 cycle; busy=0; go to IDLE.
- Latency, single element: 2 read latencies + multiply latency + accumulator latency + 7 cycles of sequencing overhead.
- Address arithmetic: modulo 2^ADDR_WIDTH; wrap-around is permitted and not flagged.
- idx: LEN_WIDTH bits. vec_len = 2^LEN_WIDTH−1 is supported.
- start while busy: ignored; latched parameters do not change.
- Stray read_data_valid, mul_result_valid or acc_result_last outside the matching WAIT state: ignored.
- Timeout: a counter resets on entry to each WAIT state. Reaching TIMEOUT_CYCLES gives error=1 for 1 cycle, busy=0, return to IDLE; result is unchanged (0). If the stall is in WAIT_ACC, the accumulator has already seen tlast and needs no flush.
- A valid strobe arriving in the same cycle the timeout fires: the timeout wins.
- done and error are never high together.
- Strobes (read_req, mul_valid, acc_valid, acc_last, done, error) are registered outputs, 0 outside their state. Operand and data outputs hold their last values.

Test Plan:
- Reset mid-operation in WAIT_MUL → all outputs 0 on the next edge with no clock needed; a subsequent start works normally.
- vec_len=3, base_a=0x100, base_b=0x200, A={0x3C00,0x4000,0x4200}, B={0x3C00 ×3}, with behavioral mul/acc latency 4 → reads at 0x100,0x200,0x101,0x201,0x102,0x202 in order; acc_last only on the 3rd acc_valid; result=0x4600; one done pulse.
- vec_len=0 → done 2 cycles after start; read_req, mul_valid and acc_valid never assert; result=0x0000.
- start re-pulsed while busy with different base_a → read addresses unchanged; exactly one done.
- read_data_valid withheld, TIMEOUT_CYCLES=16 → error pulse 16 cycles after entering WAIT_A; busy drops; no done.
- base_a=0x7FFFFFF, vec_len=2 → second A read at address 0x0000000.
